// File: rtl/fmap_loader.sv
`default_nettype none
// ============================================================================
// Module      : fmap_loader
// Description : Streams one IMG_W x IMG_H feature map and a KERN_N-byte
//               kernel into a scratchpad and serves two image read ports
//               and one kernel read port. Optional macro LOAD_CHECKSUM_EN
//               adds o_checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_loader #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int KERN_N = 9,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_img_base,
    input  logic [ADDR_W-1:0] i_kern_base,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    input  logic [ADDR_W-1:0] i_rd_kaddr,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic [DATA_W-1:0] o_rd_kdata,
    output logic              o_busy,
    output logic              o_loaded,
    output logic [4:0]        o_row,
    output logic [4:0]        o_col
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [15:0]       o_checksum
`endif
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_load_img  = 2'd1;
    localparam logic [1:0] c_st_load_kern = 2'd2;
    localparam logic [1:0] c_st_loaded    = 2'd3;

    localparam int                  c_kcnt_w    = $clog2(KERN_N + 1);
    localparam logic [c_kcnt_w-1:0] c_kern_last = c_kcnt_w'(KERN_N - 1);
    localparam logic [4:0]          c_row_last  = 5'(IMG_H - 1);
    localparam logic [4:0]          c_col_last  = 5'(IMG_W - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_img_ptr;
    logic [ADDR_W-1:0]   r_kern_ptr;
    logic [4:0]          r_row;
    logic [4:0]          r_col;
    logic [c_kcnt_w-1:0] r_kcnt;
    logic                w_accept;
    logic                w_start_ok;
    logic                w_img_last;
    logic                w_kern_last;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    assign w_accept    = i_s_valid & o_s_ready;
    assign w_start_ok  = i_start & ((r_state == c_st_idle) | (r_state == c_st_loaded));
    assign w_img_last  = (r_row == c_row_last) && (r_col == c_col_last);
    assign w_kern_last = (r_kcnt == c_kern_last);
    assign w_wr_en     = w_accept & ~i_rst;
    assign w_wr_addr   = (r_state == c_st_load_kern) ? r_kern_ptr : r_img_ptr;
    assign o_row       = r_row;
    assign o_col       = r_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_s_ready   = 1'b0;
        o_busy      = 1'b0;
        o_loaded    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_start) w_state_nxt = c_st_load_img;
            end
            c_st_load_img: begin
                o_s_ready = 1'b1;
                o_busy    = 1'b1;
                if (w_accept && w_img_last) w_state_nxt = c_st_load_kern;
            end
            c_st_load_kern: begin
                o_s_ready = 1'b1;
                o_busy    = 1'b1;
                if (w_accept && w_kern_last) w_state_nxt = c_st_loaded;
            end
            default: begin
                o_loaded = 1'b1;
                if (i_start) w_state_nxt = c_st_load_img;
            end
        endcase
    end

    // Write pointers are incremented rather than recomputed from row/col;
    // ADDR_W-bit arithmetic gives the wrap past DEPTH-1 for free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_img_ptr  <= '0;
            r_kern_ptr <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_kcnt     <= '0;
        end else if (w_start_ok) begin
            r_img_ptr  <= i_img_base;
            r_kern_ptr <= i_kern_base;
            r_row      <= '0;
            r_col      <= '0;
            r_kcnt     <= '0;
        end else if (w_accept) begin
            if (r_state == c_st_load_img) begin
                r_img_ptr <= r_img_ptr + 1'b1;
                if (r_col == c_col_last) begin
                    if (!w_img_last) begin
                        r_col <= '0;
                        r_row <= r_row + 5'd1;
                    end
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end else begin
                r_kern_ptr <= r_kern_ptr + 1'b1;
                r_kcnt     <= r_kcnt + 1'b1;
            end
        end
    end

    // Scratchpad is intentionally not reset so a reload or reset keeps data.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_s_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data1 <= '0;
            o_rd_data2 <= '0;
            o_rd_kdata <= '0;
        end else begin
            o_rd_data1 <= r_mem[i_rd_addr1];
            o_rd_data2 <= r_mem[i_rd_addr2];
            o_rd_kdata <= r_mem[i_rd_kaddr];
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + 16'(i_s_data);
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmap_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_loader
// Description : Scoreboard bench for fmap_loader (read expectations queued by
//               stimulus, popped by a monitor one cycle after each read).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fmap_loader;

    logic       clk = 1'b0;
    logic       i_rst, i_start, i_s_valid;
    logic [9:0] i_img_base, i_kern_base, i_rd_addr1, i_rd_addr2, i_rd_kaddr;
    logic [7:0] i_s_data;
    logic       o_s_ready, o_busy, o_loaded;
    logic [7:0] o_rd_data1, o_rd_data2, o_rd_kdata;
    logic [4:0] o_row, o_col;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0] o_checksum;
`endif

    always #5 clk = ~clk;

    fmap_loader dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_img_base(i_img_base), .i_kern_base(i_kern_base),
        .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_rd_addr1(i_rd_addr1), .i_rd_addr2(i_rd_addr2), .i_rd_kaddr(i_rd_kaddr),
        .o_rd_data1(o_rd_data1), .o_rd_data2(o_rd_data2), .o_rd_kdata(o_rd_kdata),
        .o_busy(o_busy), .o_loaded(o_loaded), .o_row(o_row), .o_col(o_col)
`ifdef LOAD_CHECKSUM_EN
        , .o_checksum(o_checksum)
`endif
    );

    typedef struct {
        string      name;
        bit         c1, c2, ck;
        logic [7:0] e1, e2, ek;
    } rd_exp_t;

    rd_exp_t     q[$];
    rd_exp_t     mon_e;
    logic        rd_req = 1'b0;
    logic [7:0]  mdl [1024];
    bit          mvalid [1024];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned exp_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Read data appears one cycle after the address is presented.
    always @(posedge clk) begin
        if (rd_req) begin
            #1;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: read returned with no expectation queued");
            end else begin
                mon_e = q.pop_front();
                if (mon_e.c1) chk({mon_e.name, ".rd1"}, 32'(o_rd_data1), 32'(mon_e.e1));
                if (mon_e.c2) chk({mon_e.name, ".rd2"}, 32'(o_rd_data2), 32'(mon_e.e2));
                if (mon_e.ck) chk({mon_e.name, ".kd"},  32'(o_rd_kdata), 32'(mon_e.ek));
            end
        end
    end

    task automatic read3(input string nm, input logic [9:0] a1, a2, ak,
                         input logic [7:0] e1, e2, ek);
        rd_exp_t e;
        @(negedge clk);
        i_rd_addr1 = a1; i_rd_addr2 = a2; i_rd_kaddr = ak;
        e.name = nm; e.c1 = 1; e.c2 = 1; e.ck = 1;
        e.e1 = e1; e.e2 = e2; e.ek = ek;
        q.push_back(e);
        rd_req = 1'b1;
        @(posedge clk);
        #2 rd_req = 1'b0;
    endtask

    // Image bytes (n+off) mod 256 for n=0..783, then kernel bytes 1..9.
    task automatic do_load(input logic [9:0] ib, input logic [9:0] kb, input int off,
                           input bit gaps, input int start_at, input int rst_at);
        int         cyc;
        logic [9:0] prev_a;
        cyc    = 0;
        prev_a = ib;
        @(negedge clk);
        i_img_base = ib; i_kern_base = kb; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_img_base = '0; i_kern_base = '0;
        exp_sum = 0;
        chk("busy_after_start", 32'(o_busy), 1);
        chk("loaded_after_start", 32'(o_loaded), 0);
`ifdef LOAD_CHECKSUM_EN
        chk("checksum_cleared", 32'(o_checksum), 0);
`endif
        for (int n = 0; n < 793; n++) begin
            logic [9:0] a;
            logic [7:0] d;
            bit         acc;
            int         tries;
            rd_exp_t    e;
            a = (n < 784) ? 10'(int'(ib) + n) : 10'(int'(kb) + n - 784);
            d = (n < 784) ? 8'(n + off) : 8'(n - 783);
            if (n == rst_at) begin
                i_s_valid = 1'b0; i_rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_loaded", 32'(o_loaded), 0);
                chk("rst_ready", 32'(o_s_ready), 0);
                chk("rst_busy", 32'(o_busy), 0);
                chk("rst_row", 32'(o_row), 0);
                chk("rst_col", 32'(o_col), 0);
                chk("rst_rd1", 32'(o_rd_data1), 0);
                chk("rst_rd2", 32'(o_rd_data2), 0);
                chk("rst_kd", 32'(o_rd_kdata), 0);
                @(negedge clk);
                i_rst = 1'b0;
                return;
            end
            acc   = 0;
            tries = 0;
            while (!acc) begin
                i_start = (n == start_at) && (tries == 0);
                rd_req  = 1'b0;
                if (gaps && (cyc % 3 == 2)) begin
                    i_s_valid = 1'b0;
                end else begin
                    i_s_valid = 1'b1; i_s_data = d;
                    // rd1 hits the address being written: must return the old byte.
                    i_rd_addr1 = a; i_rd_addr2 = prev_a; i_rd_kaddr = kb;
                    e.name = "stream";
                    e.c1 = mvalid[a];  e.e1 = mdl[a];
                    e.c2 = (n > 0);    e.e2 = mdl[prev_a];
                    e.ck = mvalid[kb]; e.ek = mdl[kb];
                    q.push_back(e);
                    rd_req = 1'b1;
                    acc = o_s_ready;
                end
                @(posedge clk); #1;
                cyc++;
                tries++;
                rd_req = 1'b0;
                if (acc) begin
                    mdl[a] = d; mvalid[a] = 1; exp_sum += d; prev_a = a;
                end else if (tries >= 20) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stream_timeout: byte %0d not accepted, o_s_ready=%0b required 1",
                             n, o_s_ready);
                    i_s_valid = 1'b0; i_start = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            if (n == 783) begin
                chk("row_at_kernel_entry", 32'(o_row), 27);
                chk("col_at_kernel_entry", 32'(o_col), 27);
                chk("busy_at_kernel_entry", 32'(o_busy), 1);
            end
            if (n == 791) chk("loaded_before_last", 32'(o_loaded), 0);
        end
        i_s_valid = 1'b0; i_start = 1'b0;
        chk("loaded_after_last", 32'(o_loaded), 1);
        chk("ready_after_last", 32'(o_s_ready), 0);
        chk("busy_after_last", 32'(o_busy), 0);
`ifdef LOAD_CHECKSUM_EN
        @(negedge clk);
        chk("checksum", 32'(o_checksum), 32'(exp_sum[15:0]));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_s_valid = 1'b0; i_s_data = '0;
        i_img_base = '0; i_kern_base = '0;
        i_rd_addr1 = '0; i_rd_addr2 = '0; i_rd_kaddr = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_ready", 32'(o_s_ready), 0);
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_loaded", 32'(o_loaded), 0);
        chk("reset_row", 32'(o_row), 0);
        chk("reset_col", 32'(o_col), 0);
        chk("reset_rd1", 32'(o_rd_data1), 0);
        i_rst = 1'b0;

        // Full load, bases 0/800.
        do_load(10'd0, 10'd800, 0, 0, -1, -1);
        read3("full_load", 10'd29, 10'd30, 10'd804, 8'd29, 8'd30, 8'd5);

        // Same stream with i_s_valid dropped every third cycle.
        do_load(10'd0, 10'd800, 0, 1, -1, -1);
        read3("gapped_load", 10'd29, 10'd30, 10'd804, 8'd29, 8'd30, 8'd5);

        // Image wrapping past the top of the scratchpad.
        do_load(10'd1000, 10'd800, 0, 0, -1, -1);
        read3("wrap_a", 10'd0, 10'd759, 10'd808, 8'd24, 8'd15, 8'd9);
        read3("wrap_b", 10'd1000, 10'd1023, 10'd800, 8'd0, 8'd23, 8'd1);

        // Start pulse mid-load is ignored; offset 3 distinguishes this image.
        do_load(10'd0, 10'd800, 3, 0, 100, -1);
        read3("start_ignored", 10'd29, 10'd783, 10'd804, 8'd32, 8'd18, 8'd5);

        // Reload aborted by reset at byte 50; earlier bytes persist.
        do_load(10'd0, 10'd800, 7, 0, -1, 50);
        chk("loaded_after_abort", 32'(o_loaded), 0);

        // Valid while idle must not write anything.
        @(negedge clk);
        i_s_valid = 1'b1; i_s_data = 8'hEE;
        @(negedge clk);
        chk("idle_ready_low", 32'(o_s_ready), 0);
        @(negedge clk);
        i_s_valid = 1'b0;
        read3("idle_reads", 10'd5, 10'd60, 10'd804, 8'd12, 8'd63, 8'd5);
        read3("idle_no_write", 10'd0, 10'd49, 10'd800, 8'd7, 8'd56, 8'd1);
        chk("idle_loaded", 32'(o_loaded), 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
